// File: rtl/sfifo_gen.sv
// Synchronous single-clock FIFO with standard and first-word-fall-through read modes.
// Registered status flags, threshold flags and sticky overflow/underflow.
module sfifo_gen #(
    parameter int DATA_WIDTH    = 18,
    parameter int ADDRESS_WIDTH = 7,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_THRESH  = (1 << ADDRESS_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    typedef logic [ADDRESS_WIDTH:0]   cnt_t;
    typedef logic [ADDRESS_WIDTH-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_C    = cnt_t'(AFULL_THRESH);
    localparam cnt_t AE_C    = cnt_t'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    ptr_t wptr;
    ptr_t rptr;
    cnt_t cnt_nxt;
    logic wr_ok;
    logic rd_ok;

    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // Occupancy after this edge; a simultaneous read and write cancel out.
    always_comb begin
        cnt_nxt = count;
        if (wr_ok && !rd_ok) cnt_nxt = count + cnt_t'(1);
        if (rd_ok && !wr_ok) cnt_nxt = count - cnt_t'(1);
    end

    // Storage array; contents are not reset, only written on accepted writes.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) mem[wptr] <= din;
    end

    // Pointers, occupancy, derived flags and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + ptr_t'(1);
            if (rd_ok) rptr <= rptr + ptr_t'(1);
            count        <= cnt_nxt;
            full         <= (cnt_nxt == DEPTH_C);
            almost_full  <= (cnt_nxt >= AF_C);
            almost_empty <= (cnt_nxt <= AE_C);
            overflow     <= (overflow & ~clr_err) | (wr_en & full);
            underflow    <= (underflow & ~clr_err) | (rd_en & empty);
        end
    end

    if (FWFT) begin : g_fwft
        ptr_t rptr_inc;
        assign rptr_inc = rptr + ptr_t'(1);

        // Head word stays in memory until popped; dout mirrors it once
        // presented, and empty means no word is currently presented.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout  <= '0;
                empty <= 1'b1;
            end else if (rd_ok) begin
                if (count > cnt_t'(1)) begin
                    dout  <= mem[rptr_inc];
                    empty <= 1'b0;
                end else begin
                    empty <= 1'b1;
                end
            end else if (empty && count != cnt_t'(0)) begin
                dout  <= mem[rptr];
                empty <= 1'b0;
            end
        end
    end else begin : g_std
        // Registered read data on accepted reads; empty tracks occupancy.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout  <= '0;
                empty <= 1'b1;
            end else begin
                empty <= (cnt_nxt == cnt_t'(0));
                if (rd_ok) dout <= mem[rptr];
            end
        end
    end

endmodule
